rca_word_sequencer: RTL and testbench

Multi-cycle controller that computes WIDTH-bit additions with a single shared 4-bit ripple_carry_adder. It slices the operands into nibbles and processes them least-significant first, one per clock, carrying each cout into the next cin. It sits between a word-level requester and the existing 4-bit adder datapath, and uses a valid/ready handshake on both the operand side and the result side.

---
 rtl/rca_pkg.sv | 19 +
 rtl/ripple_carry_adder.sv | 24 ++
 rtl/rca_word_sequencer.sv | 171 +++++++++++++++++
 tb/tb_rca_word_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the nibble-serial word adder.
package rca_pkg;

   // Slice width handled by the shared adder per clock.
   localparam int unsigned NIB_W = 4;

   // Sequencer state encoding.
   typedef enum logic [1:0] {
      RCA_IDLE = 2'd0,
      RCA_RUN  = 2'd1,
      RCA_DONE = 2'd2
   } rca_state_e;

   // Number of nibble slices in a word of the given width.
   function automatic int unsigned nib_count(input int unsigned width);
      return width / NIB_W;
   endfunction

endpackage : rca_pkg

// File: rtl/ripple_carry_adder.sv
// Combinational 4-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_adder
   import rca_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] sum_c,
   output logic             cout_c
);

   logic [NIB_W:0] carry_c;

   assign carry_c[0] = cin;

   // One full adder per bit; each carry feeds the next stage.
   for (genvar i = 0; i < int'(NIB_W); i++) begin : g_fa
      assign sum_c[i]       = a[i] ^ b[i] ^ carry_c[i];
      assign carry_c[i + 1] = (a[i] & b[i]) | (carry_c[i] & (a[i] ^ b[i]));
   end

   assign cout_c = carry_c[NIB_W];

endmodule : ripple_carry_adder

// File: rtl/rca_word_sequencer.sv
// Word-wide adder that time-multiplexes one 4-bit ripple_carry_adder,
// processing one nibble per clock, least-significant first.
// Optional feature: define RCA_SUB_EN to enable subtraction via in_sub.
module rca_word_sequencer
   import rca_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
);

   localparam int unsigned NIB    = nib_count(WIDTH);
   localparam int unsigned IDX_W  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int unsigned BASE_W = IDX_W + 3;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

   rca_state_e        state_q,     state_d;
   logic [WIDTH-1:0]  a_q,         a_d;
   logic [WIDTH-1:0]  b_q,         b_d;
   logic              carry_q,     carry_d;
   logic [IDX_W-1:0]  idx_q,       idx_d;
   logic [WIDTH-1:0]  out_sum_q,   out_sum_d;
   logic              out_cout_q,  out_cout_d;
   logic              in_ready_q,  in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q,      busy_d;

   logic [BASE_W-1:0] base_c;
   logic [NIB_W-1:0]  add_a_c;
   logic [NIB_W-1:0]  add_b_c;
   logic [NIB_W-1:0]  add_sum_c;
   logic              add_cout_c;
   logic              accept_c;
   logic              start_carry_c;

   // Bit offset of the nibble currently being processed.
   assign base_c  = BASE_W'(idx_q) * BASE_W'(NIB_W);
   assign add_a_c = a_q[base_c +: NIB_W];

`ifdef RCA_SUB_EN
   logic sub_q, sub_d;

   // Subtraction adds the one's complement of B; the forced carry-in completes it.
   assign add_b_c       = b_q[base_c +: NIB_W] ^ {NIB_W{sub_q}};
   assign start_carry_c = in_sub ? 1'b1 : in_cin;
`else
   logic unused_in_sub;

   assign add_b_c       = b_q[base_c +: NIB_W];
   assign start_carry_c = in_cin;
   assign unused_in_sub = in_sub;
`endif

   // Shared nibble adder, fed only from registered operands and carry.
   ripple_carry_adder u_rca (
      .a      (add_a_c),
      .b      (add_b_c),
      .cin    (carry_q),
      .sum_c  (add_sum_c),
      .cout_c (add_cout_c)
   );

   assign accept_c = in_valid && in_ready_q && (state_q == RCA_IDLE);

   // Next-state, datapath update and registered-output decode.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      idx_d       = idx_q;
      out_sum_d   = out_sum_q;
      out_cout_d  = out_cout_q;
`ifdef RCA_SUB_EN
      sub_d       = sub_q;
`endif

      unique case (state_q)
         RCA_IDLE: begin
            if (accept_c) begin
               state_d    = RCA_RUN;
               a_d        = in_a;
               b_d        = in_b;
               carry_d    = start_carry_c;
               idx_d      = '0;
               out_sum_d  = '0;
               out_cout_d = 1'b0;
`ifdef RCA_SUB_EN
               sub_d      = in_sub;
`endif
            end
         end
         RCA_RUN: begin
            out_sum_d[base_c +: NIB_W] = add_sum_c;
            carry_d                    = add_cout_c;
            if (idx_q == IDX_LAST) begin
               state_d    = RCA_DONE;
               out_cout_d = add_cout_c;
               idx_d      = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         RCA_DONE: begin
            if (out_ready) begin
               state_d = RCA_IDLE;
            end
         end
         default: begin
            state_d = RCA_IDLE;
         end
      endcase

      // Handshake flags follow the state being entered, so they are registered.
      in_ready_d  = (state_d == RCA_IDLE);
      out_valid_d = (state_d == RCA_DONE);
      busy_d      = (state_d == RCA_RUN) || (state_d == RCA_DONE);
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RCA_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef RCA_SUB_EN
         sub_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         out_sum_q   <= out_sum_d;
         out_cout_q  <= out_cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
`ifdef RCA_SUB_EN
         sub_q       <= sub_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
   assign busy      = busy_q;

endmodule : rca_word_sequencer

// File: tb/tb_rca_word_sequencer.sv
// Self-checking bench for rca_word_sequencer (WIDTH=16).
module tb_rca_word_sequencer;

   localparam int unsigned WIDTH = 16;
   localparam int          NIB   = WIDTH / 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc;

   rca_word_sequencer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain word arithmetic, bit WIDTH is the carry out.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic cin, input logic sub);
`ifdef RCA_SUB_EN
      if (sub) return {1'b0, a} - {1'b0, b} + (WIDTH+1)'(1 << WIDTH);
`endif
      return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one operation and wait (bounded) for out_valid.
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub,
                        output int lat, output bit acc_to);
      int w = 0;
      acc_to = 1'b0;
      while (in_ready !== 1'b1 && w < 20) begin
         step();
         w++;
      end
      if (in_ready !== 1'b1) acc_to = 1'b1;
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
      step();
      acc_cyc  = cyc;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      #3;
      total++; if ({in_ready, out_valid, busy, out_cout} !== 4'b0 || out_sum !== '0) begin
         bad++; $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b cout=%b sum=%h exp all 0",
                         in_ready, out_valid, busy, out_cout, out_sum); end
      step();
      total++; if (in_ready !== 1'b0) begin
         bad++; $display("FAIL reset_held_ready: got %b exp 0", in_ready); end
      rst_n = 1'b1;
      step();
      total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_release: got rdy=%b busy=%b exp rdy=1 busy=0", in_ready, busy); end
   endtask

   task automatic test_add_directed();
      logic [WIDTH-1:0] va [2] = '{16'hFFFF, 16'h1234};
      logic [WIDTH-1:0] vb [2] = '{16'h0001, 16'h4321};
      logic             vc [2] = '{1'b0, 1'b1};
      logic [WIDTH-1:0] es [2] = '{16'h0000, 16'h5556};
      logic             ec [2] = '{1'b1, 1'b0};
      int lat; bit to;
      for (int i = 0; i < 2; i++) begin
         do_op(va[i], vb[i], vc[i], 1'b0, lat, to);
         total++; if (to || lat != NIB) begin
            bad++; $display("FAIL dir%0d_latency: got %0d (timeout=%0b) exp %0d", i, lat, to, NIB); end
         total++; if (out_sum !== es[i] || out_cout !== ec[i]) begin
            bad++; $display("FAIL dir%0d_result: got %h/%b exp %h/%b", i, out_sum, out_cout, es[i], ec[i]); end
         total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL dir%0d_done_flags: got busy=%b rdy=%b exp 1/0", i, busy, in_ready); end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL dir%0d_handshake: got vld=%b rdy=%b busy=%b exp 0/1/0",
                            i, out_valid, in_ready, busy); end
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH:0] exp_r;
      int lat; bit to;
      exp_r = model(16'hA5C3, 16'h7E19, 1'b1, 1'b0);
      do_op(16'hA5C3, 16'h7E19, 1'b1, 1'b0, lat, to);
      total++; if (to || lat != NIB) begin
         bad++; $display("FAIL bp_latency: got %0d exp %0d", lat, NIB); end
      for (int s = 0; s < 5; s++) begin
         step();
         total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_cout, out_sum} !== exp_r) begin
            bad++; $display("FAIL bp_stall%0d: got vld=%b rdy=%b res=%h exp 1/0/%h",
                            s, out_valid, in_ready, {out_cout, out_sum}, exp_r); end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL bp_release: got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
   endtask

   task automatic test_ignored_request();
      logic [WIDTH:0] exp_r;
      int w = 0;
      int extra = 0;
      exp_r = model(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
      in_a = 16'h0F0F; in_b = 16'h00F1; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1; in_valid = 1'b1;
      step();
      step();
      in_valid = 1'b0;
      while (out_valid !== 1'b1 && w < 20) begin step(); w++; end
      total++; if (out_valid !== 1'b1 || {out_cout, out_sum} !== exp_r) begin
         bad++; $display("FAIL ign_result: got vld=%b res=%h exp 1/%h", out_valid, {out_cout, out_sum}, exp_r); end
      out_ready = 1'b1;
      step();
      for (int s = 0; s < 12; s++) begin
         if (out_valid === 1'b1) extra++;
         step();
      end
      out_ready = 1'b0;
      total++; if (extra != 0) begin
         bad++; $display("FAIL ign_extra_valid: got %0d extra valid cycles exp 0", extra); end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] a, b;
      logic cin;
      logic [WIDTH:0] exp_r;
      int lat; bit to;
      int prev = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
         exp_r = model(a, b, cin, 1'b0);
         do_op(a, b, cin, 1'b0, lat, to);
         total++; if (to || lat != NIB || {out_cout, out_sum} !== exp_r) begin
            bad++; $display("FAIL b2b%0d_result: got lat=%0d res=%h exp lat=%0d res=%h",
                            i, lat, {out_cout, out_sum}, NIB, exp_r); end
         if (i > 0) begin
            total++; if (acc_cyc - prev != NIB + 2) begin
               bad++; $display("FAIL b2b%0d_period: got %0d exp %0d", i, acc_cyc - prev, NIB + 2); end
         end
         prev = acc_cyc;
      end
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b;
      logic cin, sub;
      logic [WIDTH:0] exp_r;
      int lat; bit to; int stall;
      for (int i = 0; i < 40; i++) begin
         a = WIDTH'($urandom); b = WIDTH'($urandom);
         cin = 1'($urandom); sub = 1'($urandom);
         if (i == 0) begin a = '1; b = '1; cin = 1'b1; end
         exp_r = model(a, b, cin, sub);
         do_op(a, b, cin, sub, lat, to);
         total++; if (to || lat != NIB || {out_cout, out_sum} !== exp_r) begin
            bad++; $display("FAIL rnd%0d: a=%h b=%h cin=%b sub=%b got lat=%0d res=%h exp lat=%0d res=%h",
                            i, a, b, cin, sub, lat, {out_cout, out_sum}, NIB, exp_r); end
         stall = $urandom_range(0, 3);
         for (int s = 0; s < stall; s++) step();
         total++; if (out_valid !== 1'b1 || {out_cout, out_sum} !== exp_r) begin
            bad++; $display("FAIL rnd%0d_hold: got vld=%b res=%h exp 1/%h", i, out_valid, {out_cout, out_sum}, exp_r); end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
   endtask

`ifdef RCA_SUB_EN
   task automatic test_sub();
      int lat; bit to;
      do_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat, to);
      total++; if (to || out_sum !== 16'hFFFE || out_cout !== 1'b0) begin
         bad++; $display("FAIL sub_borrow: got %h/%b exp fffe/0", out_sum, out_cout); end
      out_ready = 1'b1; step(); out_ready = 1'b0;
      do_op(16'h0009, 16'h0007, 1'b0, 1'b1, lat, to);
      total++; if (to || out_sum !== 16'h0002 || out_cout !== 1'b1) begin
         bad++; $display("FAIL sub_noborrow: got %h/%b exp 0002/1", out_sum, out_cout); end
      out_ready = 1'b1; step(); out_ready = 1'b0;
   endtask
`endif

   task automatic test_reset_mid_op();
      int extra = 0;
      in_a = 16'h8888; in_b = 16'h9999; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      total++; if ({in_ready, out_valid, busy, out_cout} !== 4'b0 || out_sum !== '0) begin
         bad++; $display("FAIL midrst_outputs: got rdy=%b vld=%b busy=%b cout=%b sum=%h exp all 0",
                         in_ready, out_valid, busy, out_cout, out_sum); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL midrst_release: got rdy=%b busy=%b exp 1/0", in_ready, busy); end
      for (int s = 0; s < 12; s++) begin
         if (out_valid === 1'b1) extra++;
         step();
      end
      out_ready = 1'b0;
      total++; if (extra != 0) begin
         bad++; $display("FAIL midrst_no_valid: got %0d valid cycles exp 0", extra); end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
      test_reset();
      test_add_directed();
      test_backpressure();
      test_ignored_request();
      test_back_to_back();
      test_random();
`ifdef RCA_SUB_EN
      test_sub();
`endif
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rca_word_sequencer
